shm_pipe_shifter: RTL and testbench

// - Parametrised, pipelined successor to the SHM shift matrix. Accepts A/B word pairs (AR/ARX

---
 rtl/shm_pipe_shifter.sv | 207 ++++++++++++++++++++
 tb/tb_shm_pipe_shifter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shm_pipe_shifter.sv
// Pipelined SHM shift matrix: SHIFT/PASS/SWAP/ROT/ASHR on A/B word pairs with a valid/ready stall pipeline.
// Optional odd-parity output and input-parity checking are enabled by defining SHM_PARITY_EN.
module shm_pipe_shifter #(
  parameter int W      = 36,
  parameter int SCW    = 10,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           CROBAR,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [2:0]     in_mode,
  input  logic [SCW-1:0] in_sc,
  input  logic [3:0]     in_tag,
`ifdef SHM_PARITY_EN
  input  logic           in_a_par,
  output logic           parity_err,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sh,
  output logic [3:0]     out_tag,
  output logic           out_inh,
  output logic           out_par
);

  localparam int CW = $clog2(W);

  localparam logic [2:0] M_SHIFT  = 3'd0;
  localparam logic [2:0] M_PASS_A = 3'd1;
  localparam logic [2:0] M_PASS_B = 3'd2;
  localparam logic [2:0] M_SWAP_A = 3'd3;
  localparam logic [2:0] M_ROT    = 3'd4;
  localparam logic [2:0] M_ASHR   = 3'd5;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    mode;
    logic [CW-1:0] cnt;
    logic          inh;
    logic          zero;
    logic [3:0]    tag;
  } pay_t;

  logic [STAGES:1] r_v;
  logic [STAGES:1] w_adv;
  logic [STAGES:1] w_vsrc;
  pay_t            w_p0;
  pay_t            w_last_in;
  logic [W-1:0]    w_res;
  logic            w_load_last;
  logic [W-1:0]    r_sh;
  logic [3:0]      r_tag;
  logic            r_inh;

  // A stage advances if it or any stage downstream of it is empty, or the consumer takes the head.
  always_comb begin : adv_chain
    logic acc;
    w_adv = '0;
    acc   = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      acc      = acc | ~r_v[k];
      w_adv[k] = acc;
    end
  end

  always_comb begin
    w_vsrc    = '0;
    w_vsrc[1] = in_valid;
    for (int k = 2; k <= STAGES; k++) begin
      w_vsrc[k] = r_v[k-1];
    end
  end

  assign in_ready    = w_adv[1];
  assign out_valid   = r_v[STAGES];
  assign w_load_last = w_adv[STAGES] & w_vsrc[STAGES];

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_v <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (w_adv[k]) r_v[k] <= w_vsrc[k];
      end
    end
  end

  // Count resolution: SHIFT with sc >= W moves B into the high operand so the last stage
  // always takes the upper word of {a,b} << cnt.
  always_comb begin
    w_p0      = '0;
    w_p0.a    = in_a;
    w_p0.b    = in_b;
    w_p0.mode = in_mode;
    w_p0.tag  = in_tag;
    case (in_mode)
      M_SHIFT: begin
        if (in_sc < SCW'(W)) begin
          w_p0.cnt = CW'(in_sc);
        end else if (in_sc < SCW'(2 * W)) begin
          w_p0.a   = in_b;
          w_p0.b   = '0;
          w_p0.cnt = CW'(in_sc - SCW'(W));
          w_p0.inh = 1'b1;
        end else begin
          w_p0.zero = 1'b1;
          w_p0.inh  = 1'b1;
        end
      end
      M_ROT:  w_p0.cnt = CW'(in_sc % SCW'(W));
      M_ASHR: w_p0.cnt = (in_sc > SCW'(W - 1)) ? CW'(W - 1) : CW'(in_sc);
      M_PASS_A, M_PASS_B, M_SWAP_A: w_p0.cnt = '0;
      default: begin
        w_p0.zero = 1'b1;
        w_p0.inh  = 1'b1;
      end
    endcase
  end

  generate
    if (STAGES == 1) begin : g_one
      assign w_last_in = w_p0;
    end else begin : g_multi
      pay_t r_p [1:STAGES-1];

      always_ff @(posedge clk) begin
        if (CROBAR) begin
          for (int k = 1; k < STAGES; k++) r_p[k] <= '0;
        end else begin
          if (w_adv[1] && in_valid) r_p[1] <= w_p0;
          for (int k = 2; k < STAGES; k++) begin
            if (w_adv[k] && r_v[k-1]) r_p[k] <= r_p[k-1];
          end
        end
      end

      assign w_last_in = r_p[STAGES-1];
    end
  endgenerate

  function automatic logic [W-1:0] f_result(input pay_t p);
    logic [W-1:0] r;
    r = '0;
    if (!p.zero) begin
      case (p.mode)
        M_SHIFT:  r = W'(({p.a, p.b} << p.cnt) >> W);
        M_PASS_A: r = p.a;
        M_PASS_B: r = p.b;
        M_SWAP_A: r = {p.a[W/2-1:0], p.a[W-1:W/2]};
        M_ROT:    r = W'(({p.a, p.a} << p.cnt) >> W);
        M_ASHR:   r = W'($unsigned($signed(p.a) >>> p.cnt));
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  assign w_res = f_result(w_last_in);

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_sh  <= '0;
      r_tag <= '0;
      r_inh <= 1'b0;
    end else if (w_load_last) begin
      r_sh  <= w_res;
      r_tag <= w_last_in.tag;
      r_inh <= w_last_in.inh;
    end
  end

  assign out_sh  = r_sh;
  assign out_tag = r_tag;
  assign out_inh = r_inh;

`ifdef SHM_PARITY_EN
  logic r_par;
  logic r_perr;

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_par <= 1'b0;
    end else if (w_load_last) begin
      r_par <= ~(^w_res);
    end
  end

  // Request parity is odd over {a, a_par}; flagged only for requests actually accepted.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= in_valid & w_adv[1] & ~(^{in_a, in_a_par});
    end
  end

  assign out_par    = r_par;
  assign parity_err = r_perr;
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_shm_pipe_shifter.sv
// Bench for shm_pipe_shifter (W=36, STAGES=2): directed vector table, streaming/stall, reset and random scoreboard runs.
module tb_shm_pipe_shifter;
  localparam int W      = 36;
  localparam int SCW    = 10;
  localparam int STAGES = 2;

  logic           clk = 1'b0;
  logic           CROBAR;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [2:0]     in_mode;
  logic [SCW-1:0] in_sc;
  logic [3:0]     in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sh;
  logic [3:0]     out_tag;
  logic           out_inh;
  logic           out_par;

  always #5 clk = ~clk;

  shm_pipe_shifter #(.W(W), .SCW(SCW), .STAGES(STAGES)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_sc(in_sc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sh(out_sh), .out_tag(out_tag), .out_inh(out_inh), .out_par(out_par)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: each result bit is picked from its source bit by the mode's rule.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] mode, input int sc);
    logic [2*W-1:0] cat;
    logic [W-1:0]   r;
    logic           inh;
    int             s;
    int             src;
    cat = {a, b};
    r   = '0;
    inh = 1'b0;
    case (mode)
      3'd0: begin
        for (int i = 0; i < W; i++) begin
          src = i + W - sc;
          if (src >= 0 && src < 2 * W) r[i] = cat[src];
        end
        inh = (sc >= W);
      end
      3'd1: r = a;
      3'd2: r = b;
      3'd3: for (int i = 0; i < W; i++) r[i] = a[(i + W / 2) % W];
      3'd4: begin
        s = sc % W;
        for (int i = 0; i < W; i++) r[i] = a[(i - s + W) % W];
      end
      3'd5: begin
        s = (sc > W - 1) ? W - 1 : sc;
        for (int i = 0; i < W; i++) r[i] = (i + s <= W - 1) ? a[i + s] : a[W-1];
      end
      default: inh = 1'b1;
    endcase
    return {inh, r};
  endfunction

  typedef struct packed {
    logic [W-1:0] sh;
    logic         inh;
    logic [3:0]   tag;
  } exp_t;

  exp_t         q[$];
  logic         stall_pending = 1'b0;
  logic [W-1:0] saved_sh;
  logic [3:0]   saved_tag;
  logic         saved_inh;
  int           n_deliv;

  // One clock of scoreboarded traffic; entered and left on a falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] m, input logic [SCW-1:0] sc, input logic [3:0] tag,
                       input logic ordy, output logic accepted);
    logic [W:0] r;
    exp_t       e;
    in_valid = v; in_a = a; in_b = b; in_mode = m; in_sc = sc; in_tag = tag;
    out_ready = ordy;
    #1;
    if (stall_pending) begin
      chk("stall out_valid", out_valid, 1);
      chk("stall out_sh", out_sh, saved_sh);
      chk("stall out_tag", out_tag, saved_tag);
      chk("stall out_inh", out_inh, saved_inh);
    end
    chk("in_ready vs occupancy", in_ready, (q.size() < STAGES) || ordy);
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("unexpected out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("sb out_sh", out_sh, e.sh);
        chk("sb out_inh", out_inh, e.inh);
        chk("sb out_tag", out_tag, e.tag);
        chk("sb out_par", out_par, 0);
        n_deliv++;
      end
    end
    accepted = v && in_ready;
    if (accepted) begin
      r = model(a, b, m, int'(sc));
      e.sh = r[W-1:0]; e.inh = r[W]; e.tag = tag;
      q.push_back(e);
    end
    stall_pending = out_valid && !ordy;
    saved_sh = out_sh; saved_tag = out_tag; saved_inh = out_inh;
    @(negedge clk);
  endtask

  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] m, input logic [SCW-1:0] sc, input logic [3:0] tag,
                        input logic [W-1:0] exp_sh, input logic exp_inh);
    int cyc;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; in_sc = sc; in_tag = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, cyc + 1, STAGES);
    chk({name, " out_sh"}, out_sh, exp_sh);
    chk({name, " out_inh"}, out_inh, exp_inh);
    chk({name, " out_tag"}, out_tag, tag);
    chk({name, " out_par"}, out_par, 0);
    @(negedge clk);
    chk({name, " drained"}, out_valid, 0);
  endtask

  typedef struct {
    string          name;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     mode;
    logic [SCW-1:0] sc;
    logic [W-1:0]   exp_sh;
    logic           exp_inh;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           acc;
    int             tg;
    int             cyc;
    int             ix;
    logic [W-1:0]   sa [10];
    logic [W-1:0]   sb [10];
    logic [2:0]     sm [10];
    logic [SCW-1:0] ss [10];
    logic [SCW-1:0] rsc;
    logic [SCW-1:0] edges [6];

    tbl[0]  = '{"shift3",    36'o123456_701234, 36'o567012_345670, 3'd0, 10'd3,   36'o234567_012345, 1'b0};
    tbl[1]  = '{"shift6",    36'o123456_701234, 36'o567012_345670, 3'd0, 10'd6,   36'o345670_123456, 1'b0};
    tbl[2]  = '{"shift40",   36'o777777_777777, 36'o000000_000001, 3'd0, 10'd40,  36'o000000_000020, 1'b1};
    tbl[3]  = '{"shift72",   36'o777777_777777, 36'o777777_777777, 3'd0, 10'd72,  36'o0,             1'b1};
    tbl[4]  = '{"shift0",    36'o123456_701234, 36'o567012_345670, 3'd0, 10'd0,   36'o123456_701234, 1'b0};
    tbl[5]  = '{"shift35",   36'o000000_000001, 36'o400000_000000, 3'd0, 10'd35,  36'o600000_000000, 1'b0};
    tbl[6]  = '{"shift71",   36'o777777_777777, 36'o000000_000001, 3'd0, 10'd71,  36'o400000_000000, 1'b1};
    tbl[7]  = '{"shift36",   36'o111111_111111, 36'o765432_101234, 3'd0, 10'd36,  36'o765432_101234, 1'b1};
    tbl[8]  = '{"pass_a",    36'o111111_222222, 36'o333333_444444, 3'd1, 10'd500, 36'o111111_222222, 1'b0};
    tbl[9]  = '{"pass_b",    36'o111111_222222, 36'o765432_101234, 3'd2, 10'd900, 36'o765432_101234, 1'b0};
    tbl[10] = '{"swap_a",    36'o111111_222222, 36'o0,             3'd3, 10'd7,   36'o222222_111111, 1'b0};
    tbl[11] = '{"rot37",     36'o400000_000000, 36'o0,             3'd4, 10'd37,  36'o000000_000001, 1'b0};
    tbl[12] = '{"rot0",      36'o400000_000001, 36'o0,             3'd4, 10'd0,   36'o400000_000001, 1'b0};
    tbl[13] = '{"ashr3",     36'o400000_000000, 36'o0,             3'd5, 10'd3,   36'o740000_000000, 1'b0};
    tbl[14] = '{"ashr_clamp",36'o400000_000000, 36'o0,             3'd5, 10'd100, 36'o777777_777777, 1'b0};
    tbl[15] = '{"ashr_pos",  36'o377777_777777, 36'o0,             3'd5, 10'd1,   36'o177777_777777, 1'b0};
    tbl[16] = '{"reserved6", 36'o777777_777777, 36'o777777_777777, 3'd6, 10'd1,   36'o0,             1'b1};

    CROBAR = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_sc = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    CROBAR = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_sh", out_sh, 0);
    chk("reset out_tag", out_tag, 0);
    chk("reset out_inh", out_inh, 0);
    chk("reset out_par", out_par, 0);

    for (int i = 0; i < 17; i++) begin
      single(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].sc, 4'(i),
             tbl[i].exp_sh, tbl[i].exp_inh);
    end
    single("reserved7", 36'o123, 36'o456, 3'd7, 10'd0, 4'd9, 36'o0, 1'b1);

    // Streaming tags 0..9, consumer ready two clocks on, two off.
    for (int i = 0; i < 10; i++) begin
      sa[i] = {$urandom(), $urandom()} & {W{1'b1}};
      sb[i] = {$urandom(), $urandom()} & {W{1'b1}};
      sm[i] = 3'($urandom_range(0, 5));
      ss[i] = 10'($urandom_range(0, 80));
    end
    n_deliv = 0; tg = 0; cyc = 0;
    while ((tg < 10 || q.size() > 0) && cyc < 200) begin
      ix = (tg < 10) ? tg : 0;
      cycle(tg < 10, sa[ix], sb[ix], sm[ix], ss[ix], 4'(tg), ((cyc / 2) % 2) == 0, acc);
      if (acc) tg++;
      cyc++;
    end
    chk("stream delivered", n_deliv, 10);
    chk("stream leftover", q.size(), 0);

    // Random traffic against the scoreboard.
    edges[0] = 10'd0; edges[1] = 10'd35; edges[2] = 10'd36;
    edges[3] = 10'd71; edges[4] = 10'd72; edges[5] = 10'd1023;
    n_deliv = 0;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       rsc = 10'($urandom_range(0, 35));
        1:       rsc = 10'($urandom_range(36, 71));
        2:       rsc = 10'($urandom_range(72, 1023));
        default: rsc = edges[$urandom_range(0, 5)];
      endcase
      cycle($urandom_range(0, 3) != 0, {$urandom(), $urandom()} & {W{1'b1}},
            {$urandom(), $urandom()} & {W{1'b1}}, 3'($urandom_range(0, 7)), rsc,
            4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, acc);
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      cycle(1'b0, '0, '0, 3'd0, '0, 4'd0, 1'b1, acc);
      cyc++;
    end
    chk("random drained", q.size(), 0);
    chk("random some delivered", n_deliv > 50, 1);

    // Reset with two items in flight drops them.
    cycle(1'b1, 36'o0, 36'o777777_777777, 3'd0, 10'd36, 4'd5, 1'b0, acc);
    cycle(1'b1, 36'o123, 36'o456, 3'd1, 10'd0, 4'd6, 1'b0, acc);
    chk("pre-reset out_valid", out_valid, 1);
    CROBAR = 1'b1;
    in_valid = 1'b1; in_a = 36'o555; in_mode = 3'd1; in_tag = 4'd11;
    @(negedge clk);
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_sh", out_sh, 0);
    chk("midreset out_tag", out_tag, 0);
    chk("midreset out_inh", out_inh, 0);
    chk("midreset out_par", out_par, 0);
    chk("midreset in_ready", in_ready, 1);
    @(negedge clk);
    CROBAR = 1'b0; in_valid = 1'b0;
    q.delete();
    stall_pending = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ignored during reset", out_valid, 0);
    end
    single("after reset", 36'o400000_000000, 36'o0, 3'd4, 10'd37, 4'd3, 36'o000000_000001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
